tx_byte_queue: RTL and testbench
================================

TX_BYTE_QUEUE -- requirements
Module: tx_byte_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of byte entries; power of 2, minimum 4.
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port wr_data  input  8  byte to enqueue.
REQ-005 SHALL have port wr_en  input  1  single-cycle byte push strobe.
REQ-006 SHALL have port wr_word  input  32  word to enqueue as 4 bytes.
REQ-007 SHALL have port wr_word_en  input  1  single-cycle word push strobe.
REQ-008 SHALL have port uart_data  output  8  byte presented to the UART transmitter.
REQ-009 SHALL have port uart_enable  output  1  one-cycle send strobe to the UART transmitter.
REQ-010 SHALL have port uart_ready  input  1  transmitter idle flag; drops while sending.
REQ-011 SHALL have port empty  output  1  queue holds zero entries.
REQ-012 SHALL have port full  output  1  queue holds DEPTH entries.
REQ-013 SHALL have port free_count  output  $clog2(DEPTH)+1  number of free entries.
REQ-014 SHALL have port overflow  output  1  one-cycle pulse on any dropped push.

Function
REQ-015 SHALL store entries FIFO-ordered; pointers wrap modulo DEPTH; occupancy is a separate counter.
REQ-016 SHALL accept a byte push only when wr_en=1 and full=0 at the clock edge.
REQ-017 SHALL accept a word push only when wr_word_en=1 and free_count>=4; all 4 bytes are written in that cycle, MSB (wr_word[31:24]) first out.
REQ-018 SHALL reject a word push entirely when free_count<4; partial words are never enqueued.
REQ-019 SHALL give wr_word_en priority when both strobes coincide; the byte push is dropped.
REQ-020 SHALL pulse overflow for one cycle the cycle after any dropped push (full, insufficient space, or collision).
REQ-021 SHALL evaluate full/free_count at the start of the cycle; a pop in the same cycle does not admit a push rejected as full.
REQ-022 SHALL apply a simultaneous accepted push and pop in one cycle, with occupancy changing by pushes minus 1.
REQ-023 SHALL run drain FSM states IDLE, WAIT_BUSY, WAIT_DONE.
REQ-024 IDLE: when empty=0 and uart_ready=1, SHALL present the head byte on uart_data, pulse uart_enable for exactly one cycle, pop the head, and go to WAIT_BUSY.
REQ-025 WAIT_BUSY: SHALL go to WAIT_DONE when uart_ready=0; if uart_ready stays high for 4 cycles, SHALL go to IDLE (lost-handshake guard).
REQ-026 WAIT_DONE: SHALL go to IDLE when uart_ready=1.
REQ-027 SHALL hold uart_data stable from the strobe cycle until the next strobe.
REQ-028 SHALL have latency from push into an empty queue with uart_ready=1 to uart_enable of 2 cycles.

Reset
REQ-029 Assertion of reset SHALL immediately clear pointers and occupancy, set FSM to IDLE, and set empty=1, full=0, free_count=DEPTH, uart_enable=0, uart_data=0, overflow=0.
REQ-030 Reset mid-transfer SHALL discard all queued bytes; no uart_enable is issued until a new push after release.

Configuration
REQ-031 With TX_QUEUE_DROP_CNT_EN defined, SHALL add output drop_count[15:0], incremented per dropped push (a word counts 1), saturating at 0xFFFF, cleared by reset.
REQ-032 Without TX_QUEUE_DROP_CNT_EN, drop_count and its logic SHALL be absent; overflow pulse behaviour is unchanged.

Structure
REQ-033 Package glitcher_pkg SHALL hold UART_BYTE_W=8, TX_QUEUE_DEPTH_DEF=16, BUSY_GUARD_CYCLES=4, and the drain FSM state enum.
REQ-034 Storage and pointers SHALL live in sub-module byte_fifo, with 1-or-4-byte write and 1-byte read; tx_byte_queue holds the FSM, admission logic and counter.

Verification
REQ-035 Push 0x47 with uart_ready=1 -> uart_enable 2 cycles later with uart_data=0x47; empty=1 afterwards.
REQ-036 wr_word=0xDEADBEEF with a model UART (ready low 10 cycles per byte) -> bytes DE, AD, BE, EF in order, one strobe each, each only after ready returns high.
REQ-037 Fill 16 bytes with uart_ready=0, then push a byte -> full=1, overflow pulse, queue contents unchanged; with macro, drop_count=1.
REQ-038 free_count=3, push a word -> rejected whole, overflow pulse, free_count stays 3; wr_en and wr_word_en together on an empty queue -> 4 entries, overflow pulse.
REQ-039 Assert reset while in WAIT_DONE with 5 bytes queued -> empty=1, free_count=16, no uart_enable after release until a new push.
REQ-040 uart_ready held high after a strobe -> FSM returns to IDLE after 4 cycles and sends the next byte.

Source files
------------

// File: rtl/glitcher_pkg.sv
// Shared constants and drain FSM state encoding for the UART transmit queue.
package glitcher_pkg;

    localparam int UART_BYTE_W        = 8;
    localparam int TX_QUEUE_DEPTH_DEF = 16;
    localparam int BUSY_GUARD_CYCLES  = 4;

    typedef enum logic [1:0] {
        DRAIN_IDLE      = 2'd0,
        DRAIN_WAIT_BUSY = 2'd1,
        DRAIN_WAIT_DONE = 2'd2
    } drain_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide circular storage with a 1-or-4-byte write port and a 1-byte read.
// Admission decisions are made by the caller; this block trusts push/pop.
module byte_fifo
    import glitcher_pkg::*;
#(
    parameter int DEPTH = TX_QUEUE_DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_byte,
    input  logic [UART_BYTE_W-1:0]   byte_in,
    input  logic                     push_word,
    input  logic [31:0]              word_in,
    input  logic                     pop,
    output logic [UART_BYTE_W-1:0]   head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [UART_BYTE_W-1:0] mem [DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [CW-1:0]          push_n;
    logic [CW-1:0]          pop_n;

    assign push_n = push_word ? CW'(4) : (push_byte ? CW'(1) : '0);
    assign pop_n  = pop ? CW'(1) : '0;
    assign head   = mem[rd_ptr];

    // Storage write: a word lands MSB first so it also leaves MSB first.
    always_ff @(posedge clk) begin
        if (push_word) begin
            mem[wr_ptr]          <= word_in[31:24];
            mem[wr_ptr + AW'(1)] <= word_in[23:16];
            mem[wr_ptr + AW'(2)] <= word_in[15:8];
            mem[wr_ptr + AW'(3)] <= word_in[7:0];
        end else if (push_byte) begin
            mem[wr_ptr] <= byte_in;
        end
    end

    // Pointers wrap naturally at DEPTH; occupancy tracked separately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_word)      wr_ptr <= wr_ptr + AW'(4);
            else if (push_byte) wr_ptr <= wr_ptr + AW'(1);
            if (pop)            rd_ptr <= rd_ptr + AW'(1);
            count <= count + push_n - pop_n;
        end
    end

endmodule

// File: rtl/tx_byte_queue.sv
// UART transmit queue: admission of byte/word pushes, drain FSM that hands
// one byte at a time to the transmitter, and overflow reporting.
// Optional feature macro: TX_QUEUE_DROP_CNT_EN adds a saturating drop_count.
module tx_byte_queue
    import glitcher_pkg::*;
#(
    parameter int DEPTH = TX_QUEUE_DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [UART_BYTE_W-1:0]   wr_data,
    input  logic                     wr_en,
    input  logic [31:0]              wr_word,
    input  logic                     wr_word_en,
    output logic [UART_BYTE_W-1:0]   uart_data,
    output logic                     uart_enable,
    input  logic                     uart_ready,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   free_count,
    output logic                     overflow
`ifdef TX_QUEUE_DROP_CNT_EN
    ,
    output logic [15:0]              drop_count
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int GW = $clog2(BUSY_GUARD_CYCLES);

    drain_state_t           state;
    logic [GW-1:0]          guard_cnt;
    logic [CW-1:0]          count;
    logic [UART_BYTE_W-1:0] head;
    logic                   word_acc, word_drop, byte_acc, byte_drop, pop;

    // Status comes from registered occupancy, so a same-cycle pop never
    // makes room for a push.
    assign empty      = (count == '0);
    assign full       = (count == CW'(DEPTH));
    assign free_count = CW'(DEPTH) - count;

    // Word strobe wins a collision; a word never goes in partially.
    assign word_acc  = wr_word_en && (free_count >= CW'(4));
    assign word_drop = wr_word_en && !word_acc;
    assign byte_acc  = wr_en && !wr_word_en && !full;
    assign byte_drop = wr_en && !byte_acc;

    assign pop = (state == DRAIN_IDLE) && !empty && uart_ready;

    byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push_byte (byte_acc),
        .byte_in   (wr_data),
        .push_word (word_acc),
        .word_in   (wr_word),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    // Drain FSM: strobe one byte, wait for the transmitter to go busy and
    // come back idle; give up waiting for busy after the guard window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= DRAIN_IDLE;
            guard_cnt   <= '0;
            uart_enable <= 1'b0;
            uart_data   <= '0;
        end else begin
            uart_enable <= 1'b0;
            case (state)
                DRAIN_IDLE: begin
                    if (pop) begin
                        uart_enable <= 1'b1;
                        uart_data   <= head;
                        guard_cnt   <= '0;
                        state       <= DRAIN_WAIT_BUSY;
                    end
                end
                DRAIN_WAIT_BUSY: begin
                    if (!uart_ready)
                        state <= DRAIN_WAIT_DONE;
                    else if (guard_cnt == GW'(BUSY_GUARD_CYCLES - 1))
                        state <= DRAIN_IDLE;
                    else
                        guard_cnt <= guard_cnt + GW'(1);
                end
                DRAIN_WAIT_DONE: begin
                    if (uart_ready) state <= DRAIN_IDLE;
                end
                default: state <= DRAIN_IDLE;
            endcase
        end
    end

    // Overflow pulses the cycle after any dropped push.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) overflow <= 1'b0;
        else       overflow <= word_drop || byte_drop;
    end

`ifdef TX_QUEUE_DROP_CNT_EN
    logic [16:0] drop_sum;
    assign drop_sum = {1'b0, drop_count} + 17'(word_drop) + 17'(byte_drop);

    // Saturating count of dropped pushes (a word counts as one).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) drop_count <= '0;
        else       drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
`endif

endmodule

// File: tb/tb_tx_byte_queue.sv
// Directed bench for tx_byte_queue with a simple UART model.
module tb_tx_byte_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  wr_data;
    logic        wr_en;
    logic [31:0] wr_word;
    logic        wr_word_en;
    logic [7:0]  uart_data;
    logic        uart_enable;
    logic        uart_ready;
    logic        empty, full, overflow;
    logic [4:0]  free_count;
`ifdef TX_QUEUE_DROP_CNT_EN
    logic [15:0] drop_count;
`endif

    logic man_ready;
    logic model_on;
    int   busy_cnt = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    assign uart_ready = model_on ? (busy_cnt == 0) : man_ready;

    // UART model: busy for 10 cycles after each strobe
    always @(posedge clk) begin
        if (model_on && uart_enable) busy_cnt <= 10;
        else if (busy_cnt != 0)      busy_cnt <= busy_cnt - 1;
    end

    tx_byte_queue #(.DEPTH(16)) dut (
        .clk(clk), .reset(reset), .wr_data(wr_data), .wr_en(wr_en),
        .wr_word(wr_word), .wr_word_en(wr_word_en), .uart_data(uart_data),
        .uart_enable(uart_enable), .uart_ready(uart_ready), .empty(empty),
        .full(full), .free_count(free_count), .overflow(overflow)
`ifdef TX_QUEUE_DROP_CNT_EN
        , .drop_count(drop_count)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_strobe(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (uart_enable) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(2);
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
        checks++; if (free_count !== 5'd16) begin errors++; $display("FAIL reset_free: got %0d want 16", free_count); end
        checks++; if (uart_enable !== 1'b0) begin errors++; $display("FAIL reset_enable: got %b want 0", uart_enable); end
        checks++; if (uart_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", uart_data); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_byte();
        man_ready = 1'b1;
        wr_data = 8'h47; wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        checks++; if (uart_enable !== 1'b0) begin errors++; $display("FAIL single_early: got %b want 0", uart_enable); end
        tick();
        checks++; if (uart_enable !== 1'b1) begin errors++; $display("FAIL single_strobe: got %b want 1", uart_enable); end
        checks++; if (uart_data !== 8'h47) begin errors++; $display("FAIL single_data: got %h want 47", uart_data); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty: got %b want 1", empty); end
        tick();
        checks++; if (uart_enable !== 1'b0 || uart_data !== 8'h47) begin errors++; $display("FAIL single_hold: en %b data %h want 0/47", uart_enable, uart_data); end
        idle(8);
    endtask

    task automatic test_guard();
        bit extra = 1'b0;
        man_ready = 1'b1;
        wr_data = 8'h11; wr_en = 1'b1;
        tick();
        checks++; if (uart_enable !== 1'b0) begin errors++; $display("FAIL guard_early: got %b want 0", uart_enable); end
        wr_data = 8'h22;
        tick();
        wr_en = 1'b0;
        checks++; if (uart_enable !== 1'b1 || uart_data !== 8'h11) begin errors++; $display("FAIL guard_first: en %b data %h want 1/11", uart_enable, uart_data); end
        checks++; if (free_count !== 5'd15) begin errors++; $display("FAIL guard_pushpop_free: got %0d want 15", free_count); end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (uart_enable || uart_data !== 8'h11) extra = 1'b1;
        end
        checks++; if (extra !== 1'b0) begin errors++; $display("FAIL guard_window: got strobe/data change %b want 0", extra); end
        tick();
        checks++; if (uart_enable !== 1'b1 || uart_data !== 8'h22) begin errors++; $display("FAIL guard_second: en %b data %h want 1/22", uart_enable, uart_data); end
        idle(8);
    endtask

    task automatic test_word_drain();
        logic [7:0] exp [4];
        logic [7:0] got [4];
        int cyc [4];
        int n = 0;
        bit bad_ready = 1'b0, dbl = 1'b0, prev = 1'b0;
        exp[0] = 8'hDE; exp[1] = 8'hAD; exp[2] = 8'hBE; exp[3] = 8'hEF;
        model_on = 1'b1;
        wr_word = 32'hDEADBEEF; wr_word_en = 1'b1;
        tick();
        wr_word_en = 1'b0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (uart_enable) begin
                if (prev) dbl = 1'b1;
                if (uart_ready !== 1'b1) bad_ready = 1'b1;
                if (n < 4) begin got[n] = uart_data; cyc[n] = c; end
                n++;
            end
            prev = uart_enable;
        end
        checks++; if (n !== 4) begin errors++; $display("FAIL word_strobes: got %0d want 4", n); end
        checks++; if (dbl !== 1'b0 || bad_ready !== 1'b0) begin errors++; $display("FAIL word_handshake: dbl %b early %b want 0/0", dbl, bad_ready); end
        for (int i = 0; i < 4 && i < n; i++) begin
            checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL word_byte%0d: got %h want %h", i, got[i], exp[i]); end
        end
        for (int i = 1; i < 4 && i < n; i++) begin
            checks++; if (cyc[i] - cyc[i-1] !== 13) begin errors++; $display("FAIL word_gap%0d: got %0d want 13", i, cyc[i] - cyc[i-1]); end
        end
        model_on = 1'b0;
    endtask

    task automatic test_full();
        bit seen;
        man_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wr_data = 8'(8'h30 + i); wr_en = 1'b1;
            tick();
        end
        wr_data = 8'hAA;
        checks++; if (full !== 1'b1 || free_count !== 5'd0) begin errors++; $display("FAIL full_flag: full %b free %0d want 1/0", full, free_count); end
        tick();
        wr_en = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL full_overflow: got %b want 1", overflow); end
`ifdef TX_QUEUE_DROP_CNT_EN
        checks++; if (drop_count !== 16'd1) begin errors++; $display("FAIL full_drop_count: got %0d want 1", drop_count); end
`endif
        tick();
        checks++; if (overflow !== 1'b0 || full !== 1'b1) begin errors++; $display("FAIL full_after: ovf %b full %b want 0/1", overflow, full); end
        man_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wait_strobe(20, seen);
            checks++; if (!seen || uart_data !== 8'(8'h30 + i)) begin errors++; $display("FAIL full_drain%0d: seen %b got %h want %h", i, seen, uart_data, 8'(8'h30 + i)); end
        end
        idle(8);
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL full_drained: got %b want 1", empty); end
    endtask

    task automatic test_word_reject();
        bit seen;
        logic [7:0] exp [4];
        exp[0] = 8'h01; exp[1] = 8'h02; exp[2] = 8'h03; exp[3] = 8'h04;
        man_ready = 1'b0;
        for (int i = 0; i < 13; i++) begin
            wr_data = 8'(i); wr_en = 1'b1;
            tick();
        end
        wr_en = 1'b0;
        checks++; if (free_count !== 5'd3) begin errors++; $display("FAIL rej_free_before: got %0d want 3", free_count); end
        wr_word = 32'hCAFEF00D; wr_word_en = 1'b1;
        tick();
        wr_word_en = 1'b0;
        checks++; if (overflow !== 1'b1 || free_count !== 5'd3) begin errors++; $display("FAIL rej_word: ovf %b free %0d want 1/3", overflow, free_count); end
        tick();
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rej_pulse_len: got %b want 0", overflow); end
        reset = 1'b1; tick(); reset = 1'b0; tick();
        wr_data = 8'h99; wr_en = 1'b1;
        wr_word = 32'h01020304; wr_word_en = 1'b1;
        tick();
        wr_en = 1'b0; wr_word_en = 1'b0;
        checks++; if (free_count !== 5'd12 || overflow !== 1'b1) begin errors++; $display("FAIL collide: free %0d ovf %b want 12/1", free_count, overflow); end
`ifdef TX_QUEUE_DROP_CNT_EN
        checks++; if (drop_count !== 16'd1) begin errors++; $display("FAIL collide_drop_count: got %0d want 1", drop_count); end
`endif
        man_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_strobe(20, seen);
            checks++; if (!seen || uart_data !== exp[i]) begin errors++; $display("FAIL collide_byte%0d: seen %b got %h want %h", i, seen, uart_data, exp[i]); end
        end
        idle(8);
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL collide_empty: got %b want 1", empty); end
    endtask

    task automatic test_reset_mid();
        bit seen;
        int strobes = 0;
        model_on = 1'b1;
        wr_word = 32'h10203040; wr_word_en = 1'b1;
        tick();
        wr_word_en = 1'b0;
        wr_data = 8'h50; wr_en = 1'b1;
        tick();
        wr_data = 8'h60;
        tick();
        wr_en = 1'b0;
        idle(3);
        checks++; if (free_count !== 5'd11) begin errors++; $display("FAIL mid_free_before: got %0d want 11", free_count); end
        reset = 1'b1;
        #1;
        checks++; if (empty !== 1'b1 || free_count !== 5'd16 || uart_enable !== 1'b0) begin errors++; $display("FAIL mid_async: empty %b free %0d en %b want 1/16/0", empty, free_count, uart_enable); end
        idle(2);
        reset = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (uart_enable) strobes++;
        end
        checks++; if (strobes !== 0) begin errors++; $display("FAIL mid_no_strobe: got %0d want 0", strobes); end
        wr_data = 8'h5A; wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        wait_strobe(10, seen);
        checks++; if (!seen || uart_data !== 8'h5A) begin errors++; $display("FAIL mid_new_push: seen %b got %h want 5a", seen, uart_data); end
        idle(20);
        model_on = 1'b0;
    endtask

    initial begin
        reset = 1'b1; wr_data = '0; wr_en = 1'b0; wr_word = '0; wr_word_en = 1'b0;
        man_ready = 1'b0; model_on = 1'b0;
        test_reset();
        test_single_byte();
        test_guard();
        test_word_drain();
        test_full();
        test_word_reject();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
